// File: rtl/conv_pkg.sv
// Shared widths, window/filter types and FSM state encoding for the
// X-convolution window feeder.
package conv_pkg;
    localparam int PIX_W  = 4;
    localparam int COEF_W = 5;
    localparam int CONV_W = 10;
    localparam int K      = 3;

    typedef logic [K-1:0][K-1:0][PIX_W-1:0]  window_t;
    typedef logic [K-1:0][K-1:0][COEF_W-1:0] filter_t;

    typedef enum logic [1:0] {FILL, CALC, OUT} state_e;
endpackage

// File: rtl/conv_window_feeder_if.sv
// Pixel stream, convolution-block and result handshake signals of the feeder.
// master is the feeder side, slave is the surrounding datapath.
interface conv_window_feeder_if;
    import conv_pkg::*;

    logic                 filter_load;
    filter_t              filter_in;
    logic                 pix_valid;
    logic [PIX_W-1:0]     pix_data;
    logic                 pix_ready;
    logic                 calc_enable;
    window_t              pixels;
    filter_t              filter;
    logic                 calc_done;
    logic [CONV_W-1:0]    conv;
    logic                 res_valid;
    logic [CONV_W-1:0]    res_data;
    logic                 res_last;
    logic                 res_ready;

    modport master (
        input  filter_load, filter_in, pix_valid, pix_data, calc_done, conv, res_ready,
        output pix_ready, calc_enable, pixels, filter, res_valid, res_data, res_last
    );

    modport slave (
        output filter_load, filter_in, pix_valid, pix_data, calc_done, conv, res_ready,
        input  pix_ready, calc_enable, pixels, filter, res_valid, res_data, res_last
    );
endinterface

// File: rtl/conv_line_buffer.sv
// Two WIDTH-deep pixel row stores sharing one column index: lb0 holds the row
// two above the incoming pixel, lb1 the row directly above.
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CW-1:0]    col,
    input  logic             wr_en,
    input  logic [PIX_W-1:0] wr_data,
    output logic [PIX_W-1:0] rd0,
    output logic [PIX_W-1:0] rd1
);

    logic [PIX_W-1:0] lb0_q [WIDTH];
    logic [PIX_W-1:0] lb0_d [WIDTH];
    logic [PIX_W-1:0] lb1_q [WIDTH];
    logic [PIX_W-1:0] lb1_d [WIDTH];

    assign rd0 = lb0_q[col];
    assign rd1 = lb1_q[col];

    always_comb begin
        lb0_d = lb0_q;
        lb1_d = lb1_q;
        if (wr_en) begin
            lb0_d[col] = lb1_q[col];
            lb1_d[col] = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lb0_q <= '{default: '0};
            lb1_q <= '{default: '0};
        end else begin
            lb0_q <= lb0_d;
            lb1_q <= lb1_d;
        end
    end

endmodule

// File: rtl/conv_window_feeder.sv
// Builds 3x3 raster windows, hands each one with the latched filter to the
// convolution block and forwards the captured result downstream.
module conv_window_feeder
    import conv_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    conv_window_feeder_if.master bus
);

    // FILL: accepting pixels | CALC: window issued, awaiting calc_done | OUT: result held for downstream
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam logic [CW-1:0] COL_MAX = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(HEIGHT - 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       col_q, col_d;
    logic [RW-1:0]       row_q, row_d;
    window_t             win_q, win_d;
    filter_t             filt_q, filt_d;
    logic [CONV_W-1:0]   res_data_q, res_data_d;
    logic                res_last_q, res_last_d;
    logic                win_last_q, win_last_d;
    logic                calc_en_q, calc_en_d;
    logic                accept;
    logic [PIX_W-1:0]    lb_rd0, lb_rd1;

    conv_line_buffer #(.WIDTH(WIDTH)) u_line_buffer (
        .clk     (clk),
        .rst     (rst),
        .col     (col_q),
        .wr_en   (accept),
        .wr_data (bus.pix_data),
        .rd0     (lb_rd0),
        .rd1     (lb_rd1)
    );

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        win_d      = win_q;
        filt_d     = filt_q;
        res_data_d = res_data_q;
        res_last_d = res_last_q;
        win_last_d = win_last_q;
        calc_en_d  = 1'b0;
        accept     = 1'b0;
        unique case (state_q)
            FILL: begin
                if (bus.filter_load) filt_d = bus.filter_in;
                if (bus.pix_valid) begin
                    accept = 1'b1;
                    for (int r = 0; r < K; r++) begin
                        win_d[r][0] = win_q[r][1];
                        win_d[r][1] = win_q[r][2];
                    end
                    win_d[0][2] = lb_rd0;
                    win_d[1][2] = lb_rd1;
                    win_d[2][2] = bus.pix_data;
                    if (col_q == COL_MAX) begin
                        col_d = '0;
                        row_d = (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                    // Windows straddling a row wrap are rejected because col < 2 there.
                    if (row_q >= RW'(2) && col_q >= CW'(2)) begin
                        state_d    = CALC;
                        calc_en_d  = 1'b1;
                        win_last_d = (row_q == ROW_MAX) && (col_q == COL_MAX);
                    end
                end
            end
            CALC: begin
                if (bus.calc_done) begin
                    res_data_d = bus.conv;
                    res_last_d = win_last_q;
                    state_d    = OUT;
                end
            end
            OUT: begin
                if (bus.res_ready) begin
                    res_last_d = 1'b0;
                    state_d    = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FILL;
            col_q      <= '0;
            row_q      <= '0;
            win_q      <= '0;
            filt_q     <= '0;
            res_data_q <= '0;
            res_last_q <= 1'b0;
            win_last_q <= 1'b0;
            calc_en_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            win_q      <= win_d;
            filt_q     <= filt_d;
            res_data_q <= res_data_d;
            res_last_q <= res_last_d;
            win_last_q <= win_last_d;
            calc_en_q  <= calc_en_d;
        end
    end

    // Gated by rst so every output reads 0 while reset is held.
    assign bus.pix_ready   = (state_q == FILL) && !rst;
    assign bus.calc_enable = calc_en_q;
    assign bus.pixels      = win_q;
    assign bus.filter      = filt_q;
    assign bus.res_valid   = (state_q == OUT);
    assign bus.res_data    = res_data_q;
    assign bus.res_last    = res_last_q;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Bench for conv_window_feeder on a 4x4 image: raster/image model, convolution
// responder, result sink and directed frame scenarios.
module tb_conv_window_feeder;
    import conv_pkg::*;

    localparam int W = 4;
    localparam int H = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    conv_window_feeder_if ifc();

    conv_window_feeder #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- stimulus control ----------------
    int        resp_delay = 5;
    bit        spur_en    = 1'b0;
    bit        fl_calc    = 1'b0;
    bit        fl_req     = 1'b0;
    filter_t   fl_val     = '0;
    bit        sink_rand  = 1'b0;
    int        sink_hold  = 0;
    logic [9:0] conv_seq  = 10'h155;
    filter_t   filt_a, filt_b;

    // ---------------- observation ----------------
    int        cyc = 0;
    int        n_res = 0, n_last = 0, last_idx = 0, frame_acc = 0, n_win = 0;
    bit        ff_seen = 1'b0;
    int        ff_acc = 0;
    window_t   ff_win = '0;
    filter_t   win_filt [0:31];
    bit        first_en_seen = 1'b0, first_rv_seen = 1'b0;
    int        en_cyc = 0, rv_cyc = 0;
    logic [9:0] first_res = '0;

    // ---------------- behavioural model ----------------
    int          m_mode = 0;   // 0 accepting pixels, 1 calc pending, 2 result held
    logic        m_en   = 1'b0;
    int          m_r = 0, m_c = 0;
    logic [3:0]  img [0:H-1][0:W-1];
    window_t     m_win  = '0;
    filter_t     m_filt = '0;
    logic [9:0]  m_res  = '0;
    logic        m_last = 1'b0, m_wlast = 1'b0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_mode = 0; m_en = 1'b0; m_r = 0; m_c = 0;
                m_win = '0; m_filt = '0; m_res = '0; m_last = 1'b0; m_wlast = 1'b0;
            end else begin
                m_en = 1'b0;
                case (m_mode)
                    0: begin
                        if (ifc.filter_load) m_filt = ifc.filter_in;
                        if (ifc.pix_valid) begin
                            img[m_r][m_c] = ifc.pix_data;
                            if (m_r >= 2 && m_c >= 2) begin
                                for (int i = 0; i < 3; i++)
                                    for (int j = 0; j < 3; j++)
                                        m_win[i][j] = img[m_r-2+i][m_c-2+j];
                                m_wlast = (m_r == H-1) && (m_c == W-1);
                                m_mode = 1;
                                m_en = 1'b1;
                            end
                            m_c++;
                            if (m_c == W) begin
                                m_c = 0;
                                m_r = (m_r + 1) % H;
                            end
                        end
                    end
                    1: if (ifc.calc_done) begin
                        m_res = ifc.conv; m_last = m_wlast; m_mode = 2;
                    end
                    default: if (ifc.res_ready) begin
                        m_mode = 0; m_last = 1'b0;
                    end
                endcase
            end
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- compare process ----------------
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            check("pix_ready",   64'(ifc.pix_ready),   64'(m_mode == 0));
            check("calc_enable", 64'(ifc.calc_enable), 64'(m_en));
            check("res_valid",   64'(ifc.res_valid),   64'(m_mode == 2));
            check("res_last",    64'(ifc.res_last),    64'(m_last));
            check("filter",      64'(ifc.filter),      64'(m_filt));
            if (m_mode == 1) check("pixels", 64'(ifc.pixels), 64'(m_win));
            if (m_mode == 2) check("res_data", 64'(ifc.res_data), 64'(m_res));
            if (ifc.calc_enable) begin
                if (n_win < 32) win_filt[n_win] = ifc.filter;
                n_win++;
                if (!ff_seen) begin
                    ff_seen = 1'b1; ff_acc = frame_acc; ff_win = ifc.pixels;
                end
                if (!first_en_seen) begin
                    first_en_seen = 1'b1; en_cyc = cyc;
                end
            end
            if (ifc.res_valid && !first_rv_seen) begin
                first_rv_seen = 1'b1; rv_cyc = cyc; first_res = ifc.res_data;
            end
            if (ifc.res_valid && ifc.res_ready) begin
                n_res++;
                if (ifc.res_last) begin
                    n_last++; last_idx = n_res;
                end
            end
        end
    end

    // ---------------- convolution responder / filter loader ----------------
    int resp_cnt = -1;
    initial begin
        ifc.calc_done = 1'b0; ifc.conv = '0; ifc.filter_load = 1'b0; ifc.filter_in = '0;
        forever begin
            @(posedge clk); #1;
            ifc.calc_done = 1'b0;
            ifc.filter_load = 1'b0;
            if (rst) begin
                resp_cnt = -1;
            end else begin
                if (ifc.calc_enable) resp_cnt = resp_delay;
                else if (resp_cnt > 0) resp_cnt--;
                if (resp_cnt == 0) begin
                    ifc.calc_done = 1'b1; ifc.conv = conv_seq;
                    conv_seq = conv_seq + 10'h0A3;
                    resp_cnt = -1;
                end else if (spur_en && (ifc.pix_ready || ifc.res_valid)) begin
                    ifc.calc_done = 1'b1; ifc.conv = 10'h3FF;
                end
                if (fl_req && ifc.pix_ready) begin
                    ifc.filter_load = 1'b1; ifc.filter_in = fl_val; fl_req = 1'b0;
                end else if (fl_calc && !ifc.pix_ready && !ifc.res_valid) begin
                    ifc.filter_load = 1'b1; ifc.filter_in = filt_b;
                end
            end
        end
    end

    // ---------------- result sink ----------------
    int hold_cnt = 0;
    initial begin
        ifc.res_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!ifc.res_valid) begin
                hold_cnt = 0;
                ifc.res_ready = sink_rand ? 1'($urandom_range(0, 1)) : 1'b0;
            end else if (sink_rand) begin
                ifc.res_ready = 1'($urandom_range(0, 1));
            end else if (hold_cnt < sink_hold) begin
                hold_cnt++; ifc.res_ready = 1'b0;
            end else begin
                ifc.res_ready = 1'b1;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic begin_frame();
        n_res = 0; n_last = 0; last_idx = 0; frame_acc = 0; ff_seen = 1'b0;
    endtask

    task automatic send_pix(input logic [3:0] d, input bit gap);
        int  t;
        bit  acc;
        ifc.pix_valid = 1'b0;
        if (gap) repeat ($urandom_range(0, 2)) tick();
        ifc.pix_valid = 1'b1;
        ifc.pix_data  = d;
        t = 0; acc = 1'b0;
        while (!acc && t <= 300) begin
            @(negedge clk);
            acc = ifc.pix_ready;
            tick();
            t++;
        end
        if (!acc) begin
            checks++; errors++;
            $display("FAIL pix_accept_timeout: pixel %h not taken within %0d cycles", d, t);
        end else begin
            frame_acc++;
        end
        ifc.pix_valid = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int t;
        t = 0;
        while (n_res < n && t < 400) begin
            tick(); t++;
        end
        repeat (4) tick();
        check("results_per_frame", 64'(n_res), 64'(n));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        ifc.pix_valid = 1'b0;
        ifc.pix_data  = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                filt_a[r][c] = 5'(r*3 + c + 1);
                filt_b[r][c] = 5'(r*3 + c + 20);
            end

        #2 rst = 1'b1;
        #2;
        check("rst_pix_ready",   64'(ifc.pix_ready),   64'd0);
        check("rst_res_valid",   64'(ifc.res_valid),   64'd0);
        check("rst_calc_enable", 64'(ifc.calc_enable), 64'd0);
        check("rst_filter",      64'(ifc.filter),      64'd0);
        check("rst_pixels",      64'(ifc.pixels),      64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        fl_val = filt_a; fl_req = 1'b1;
        repeat (3) tick();

        // Frame 1: 0..15 back to back, responder 5 cycles, sink stalls 3 cycles.
        resp_delay = 5; sink_hold = 3;
        begin_frame();
        for (int i = 0; i < 16; i++) send_pix(4'(i), 1'b0);
        wait_results(4);
        check("f1_first_fire_after", 64'(ff_acc), 64'd11);
        check("f1_first_window", 64'(ff_win), 64'h0_A986_5421_0);
        check("f1_first_filter", 64'(win_filt[0]), 64'(filt_a));
        check("f1_first_res", 64'(first_res), 64'h155);
        check("f1_calc_to_res_cycles", 64'(rv_cyc - en_cyc), 64'd6);
        check("f1_last_count", 64'(n_last), 64'd1);
        check("f1_last_index", 64'(last_idx), 64'd4);

        // Frame 2: gaps, random sink, stray calc_done, filter load attempts during CALC.
        resp_delay = 2; spur_en = 1'b1; fl_calc = 1'b1; sink_rand = 1'b1;
        begin_frame();
        for (int i = 0; i < 16; i++) send_pix(4'((i*7 + 3) & 15), 1'b1);
        wait_results(4);
        spur_en = 1'b0; fl_calc = 1'b0; sink_rand = 1'b0;
        repeat (2) tick();
        check("f2_first_fire_after", 64'(ff_acc), 64'd11);
        check("f2_last_index", 64'(last_idx), 64'd4);
        for (int k = 4; k < 8; k++) check("f2_filter_unchanged", 64'(win_filt[k]), 64'(filt_a));
        check("f2_filter_now", 64'(ifc.filter), 64'(filt_a));

        // Frame 3: filter loaded in FILL, calc_done in the calc_enable cycle.
        fl_val = filt_b; fl_req = 1'b1;
        repeat (3) tick();
        resp_delay = 0; sink_hold = 0;
        begin_frame();
        for (int i = 0; i < 16; i++) send_pix(4'((i*5 + 1) & 15), 1'b1);
        wait_results(4);
        check("f3_new_filter", 64'(win_filt[8]), 64'(filt_b));
        check("f3_last_index", 64'(last_idx), 64'd4);

        // Frame 4: reset while a calc is outstanding.
        resp_delay = 1000;
        begin_frame();
        for (int i = 0; i < 11; i++) send_pix(4'((i*3) & 15), 1'b0);
        repeat (3) tick();
        check("f4_in_calc_pix_ready", 64'(ifc.pix_ready), 64'd0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_pix_ready",   64'(ifc.pix_ready),   64'd0);
        check("mid_rst_calc_enable", 64'(ifc.calc_enable), 64'd0);
        check("mid_rst_res_valid",   64'(ifc.res_valid),   64'd0);
        check("mid_rst_res_last",    64'(ifc.res_last),    64'd0);
        check("mid_rst_res_data",    64'(ifc.res_data),    64'd0);
        check("mid_rst_pixels",      64'(ifc.pixels),      64'd0);
        check("mid_rst_filter",      64'(ifc.filter),      64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Frame 5: fresh start at row=col=0.
        resp_delay = 3; sink_hold = 1;
        begin_frame();
        for (int i = 0; i < 16; i++) send_pix(4'(15 - i), 1'b0);
        wait_results(4);
        check("f5_first_fire_after", 64'(ff_acc), 64'd11);
        check("f5_first_window", 64'(ff_win), 64'h0_5679_ABDE_F);
        check("f5_last_index", 64'(last_idx), 64'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_window_feeder.md
Name: conv_window_feeder

Overview:
Initiator side of the X-convolution datapath. Accepts a raster stream of 4-bit pixels and builds 3x3 windows with two line buffers. For each window it presents the window and a latched 3x3 filter to the convolution block, pulses calc_enable, waits for calc_done, captures conv, and forwards the result downstream with a valid/ready handshake. It sits between the pixel input stage and the output buffer, and it drives x_conv.

Parameters:
WIDTH, 8, image width in pixels (>=3)
HEIGHT, 8, image height in pixels (>=3)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; one clock domain, asynchronous and active-high
filter_load  in  1  load filter_in into the filter register
filter_in  in  [2:0][2:0][4:0]  filter coefficients
pix_valid  in  1  pixel offered
pix_data  in  4  pixel value
pix_ready  out  1  pixel accepted when pix_valid && pix_ready
calc_enable  out  1  one-cycle start pulse to the convolution block
pixels  out  [2:0][2:0][3:0]  window; [r][c], r=0 top row, c=0 left column
filter  out  [2:0][2:0][4:0]  latched filter
calc_done  in  1  convolution complete
conv  in  10  convolution result, valid while calc_done=1
res_valid  out  1  result available
res_data  out  10  captured conv
res_last  out  1  qualifies the final result of the frame
res_ready  in  1  downstream accepts the result

Behaviour:
- Reset (async, rst=1):
  - state=FILL; row=col=0
  - window, filter register, line buffers, res_data all 0
  - calc_enable=0, res_valid=0, res_last=0
  - pix_ready=1 from the first cycle after reset release
  - A reset mid-operation aborts any pending calc or result; nothing is retained.
- States:
  - FILL: pix_ready=1.
  - CALC: pix_ready=0. calc_enable=1 only in the first CALC cycle.
  - OUT: pix_ready=0, res_valid=1.
- Pixel accept (FILL && pix_valid):
  - new column = {lb0[col], lb1[col], pix_data} for rows 0,1,2
  - window shifts left per row: [r][0]<=[r][1], [r][1]<=[r][2], [r][2]<=new[r]
  - lb0[col]<=lb1[col]; lb1[col]<=pix_data
  - col increments and wraps at WIDTH-1. On wrap, row increments and wraps at HEIGHT-1.
- Window valid:
  - Condition: the accepted pixel had row>=2 && col>=2. Then next state=CALC and the window is complete that cycle.
  - Otherwise stay in FILL. Windows straddling a row wrap never fire because col<2.
- CALC:
  - pixels and filter are held stable for the whole state.
  - Wait indefinitely for calc_done.
  - On calc_done: res_data<=conv; res_last<=(window was row HEIGHT-1, col WIDTH-1); next state=OUT.
  - calc_done arriving in the same cycle as the calc_enable pulse is legal and is captured.
- OUT:
  - res_valid, res_data and res_last are held stable until res_ready.
  - On res_valid && res_ready: next state=FILL, res_valid=0, res_last=0.
  - Zero-bubble return: pix_ready is 1 the following cycle.
- calc_done outside CALC is ignored.
- filter_load:
  - Honoured only in FILL; the register updates the next edge.
  - Ignored in CALC and OUT, so the filter never changes under an active calc.
  - If filter_load and a pixel accept coincide, both take effect. The new filter applies to the window fired by that pixel.
- Frame behaviour:
  - Results per frame = (WIDTH-2)*(HEIGHT-2), in raster order.
  - Line buffers are not cleared between frames; the row<2 gating makes stale data harmless.
- Counter widths: $clog2(WIDTH) and $clog2(HEIGHT). No arithmetic on pixel data.

Decomposition:
- Shared package conv_pkg holds:
  - PIX_W=4, COEF_W=5, CONV_W=10, K=3
  - typedefs window_t [2:0][2:0][3:0], filter_t [2:0][2:0][4:0]
  - state enum {FILL, CALC, OUT}
- One sub-module, conv_line_buffer: two WIDTH-deep 4-bit row stores with a shared col index. Read is combinational; write happens on accept.

Test Plan:
1. WIDTH=HEIGHT=4, filter 1..9, pixels 0..15 with no gaps. Required:
   - first calc_enable the cycle after pixel 10 is accepted, with pixels={0,1,2;4,5,6;8,9,10} and filter=1..9
   - exactly 4 results per frame
   - res_last only on the 4th result
2. Responder asserts calc_done 5 cycles after calc_enable with conv=10'h155. Required:
   - res_data=0x155 next cycle
   - with res_ready low for 3 cycles, res_valid/res_data stay stable and pix_ready stays 0
3. calc_done pulsed in FILL and in OUT (conv=0x3FF) -> ignored; res_data unchanged and no state change.
4. filter_load with new coefficients during CALC -> filter output unchanged. Same load during FILL -> the next window uses the new filter.
5. Back-to-back frames with random pix_valid gaps. Required:
   - the second frame's first window fires after its 11th pixel
   - windows match a raster golden model
6. rst asserted mid-CALC with res pending. Required:
   - all outputs 0 asynchronously; state FILL; filter 0
   - the next frame starts at row=col=0
